// File: rtl/mean_controller_if.sv
// Purpose: handshake and control bundle between the mean controller, the sample source and the datapath.
// Latency: wires only, no storage.
// Backpressure: carries sample_valid/sample_ready. Master is the controller and slave is the source/datapath side.
// Signals: sample_valid/clear (source -> ctrl), sample_ready, select[5:0], load[2:0],
//          mean_valid, sample_count[COUNT_W-1:0], window_done (ctrl -> source/datapath).
interface mean_controller_if #(
  parameter int COUNT_W = 8
);
  logic               sample_valid;
  logic               sample_ready;
  logic               clear;
  logic [5:0]         select;
  logic [2:0]         load;
  logic               mean_valid;
  logic [COUNT_W-1:0] sample_count;
  logic               window_done;

  modport master (
    input  sample_valid, clear,
    output sample_ready, select, load, mean_valid, sample_count, window_done
  );

  modport slave (
    output sample_valid, clear,
    input  sample_ready, select, load, mean_valid, sample_count, window_done
  );
endinterface

// File: rtl/mean_controller.sv
// Purpose: control FSM for the running-mean datapath (M <= (M>>1)+(x>>1)). It sequences select/load and publishes to REG2.
// Latency: the first sample is published 2 edges after accept and later samples 4 edges after accept. mean_valid is high in the following cycle.
// Backpressure: sample_ready is high only in IDLE, so at most one sample is in flight. clear aborts any update in flight.
// Ports: clock, reset (async, active-high); ctrl (mean_controller_if.master) carries sample_valid/ready, clear,
//        select[5:0], load[2:0] ({REG1,REG3,REG2}), mean_valid, sample_count, window_done.
// Optional: define MEAN_CTRL_WINDOW_EN to restart the mean every WINDOW samples. window_done pulses on the last publish of each window.
module mean_controller #(
  parameter int COUNT_W = 8,
  parameter int WINDOW  = 16
) (
  input  logic              clock,
  input  logic              reset,
  mean_controller_if.master ctrl
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUM     = 2'd1,
    UPDATE  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               first;
  logic               mean_valid_q;
  logic [COUNT_W-1:0] count_q;
  logic               accept;
  logic               ready_c;
  logic [5:0]         select_c;
  logic [2:0]         load_c;

  // WINDOW must fit in the window counter. A window of 1 would never fold in a sample.
  if (WINDOW < 2 || WINDOW > (1 << COUNT_W) - 1) begin : g_window_range
    $error("mean_controller: WINDOW out of range");
  end

`ifdef MEAN_CTRL_WINDOW_EN
  localparam logic [COUNT_W-1:0] WIN_LAST = COUNT_W'(WINDOW - 1);
  logic [COUNT_W-1:0] win_cnt;
  logic               win_last;      // the sample currently in flight closes the window
  logic               window_done_q;
`endif

  assign accept = ctrl.sample_valid && ready_c;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    select_c  = 6'b000000;
    load_c    = 3'b000;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (first) begin
          // Route data_in straight into REG1. The load follows valid so that REG1 holds the sample at the accepting edge.
          load_c = {ctrl.sample_valid, 2'b00};
          if (ctrl.sample_valid) state_nxt = PUBLISH;
        end else begin
          // Both shifters track their inputs while idle. The value at the accepting edge is the one that is kept.
          select_c = 6'b000111;
          if (ctrl.sample_valid) state_nxt = SUM;
        end
      end
      SUM: begin
        load_c    = 3'b010;
        state_nxt = UPDATE;
      end
      UPDATE: begin
        select_c  = 6'b001000;
        load_c    = 3'b100;
        state_nxt = PUBLISH;
      end
      PUBLISH: begin
        select_c  = 6'b100000;
        load_c    = 3'b001;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      first        <= 1'b1;
      mean_valid_q <= 1'b0;
      count_q      <= '0;
`ifdef MEAN_CTRL_WINDOW_EN
      win_cnt       <= '0;
      win_last      <= 1'b0;
      window_done_q <= 1'b0;
`endif
    end else if (ctrl.clear) begin
      // clear takes priority over any handshake in the same cycle. REG2 is left untouched.
      state        <= IDLE;
      first        <= 1'b1;
      mean_valid_q <= 1'b0;
      count_q      <= '0;
`ifdef MEAN_CTRL_WINDOW_EN
      win_cnt       <= '0;
      win_last      <= 1'b0;
      window_done_q <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      mean_valid_q <= (state == PUBLISH);
      if (accept) begin
        first <= 1'b0;
        if (count_q != '1) count_q <= count_q + 1'b1;
      end
`ifdef MEAN_CTRL_WINDOW_EN
      window_done_q <= 1'b0;
      if (accept) begin
        win_last <= (win_cnt == WIN_LAST);
        win_cnt  <= (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
      end
      // accept and PUBLISH are never in the same cycle, so this cannot conflict with clearing first.
      if (state == PUBLISH) begin
        window_done_q <= win_last;
        if (win_last) first <= 1'b1;
      end
`endif
    end
  end

  assign ctrl.sample_ready = ready_c;
  assign ctrl.select       = select_c;
  assign ctrl.load         = load_c;
  assign ctrl.mean_valid   = mean_valid_q;
  assign ctrl.sample_count = count_q;
`ifdef MEAN_CTRL_WINDOW_EN
  assign ctrl.window_done  = window_done_q;
`else
  assign ctrl.window_done  = 1'b0;
`endif

endmodule

// File: tb/tb_mean_controller.sv
// Bench for mean_controller: it includes a small datapath driven by select/load and a reference model of the mean.
// The model works on whole samples: first/mean/count/window tracked with plain arithmetic per accept.
module tb_mean_controller;

  localparam int CW  = 8;
  localparam int WIN = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mean_controller_if #(.COUNT_W(CW)) bus ();

  mean_controller #(.COUNT_W(CW), .WINDOW(WIN)) dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (bus)
  );

  // Datapath stand-in, driven only by the controller's select/load.
  logic [15:0] data_in = 16'h0;
  logic [15:0] sh_x = 16'h0, sh_m = 16'h0;
  logic [15:0] reg1 = 16'h0, reg2 = 16'h0, reg3 = 16'h0;
  always @(posedge clock) begin
    if (bus.select[0]) sh_x <= data_in >> 1;
    if (bus.select[1] && bus.select[2]) sh_m <= reg1 >> 1;
    if (bus.load[1]) reg3 <= sh_x + sh_m;
    if (bus.load[2]) reg1 <= bus.select[3] ? reg3 : data_in;
    if (bus.load[0]) reg2 <= bus.select[5] ? reg1 : reg2;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0] m_mean = 16'h0;
  logic        m_first, m_was_first, exp_wd;
  int          m_count, m_wcnt;

  // Expected select/load after the k-th edge past the accept of a non-first sample (SUM, UPDATE, PUBLISH).
  logic [5:0] exp_sel [1:3] = '{6'b000000, 6'b001000, 6'b100000};
  logic [2:0] exp_ld  [1:3] = '{3'b010, 3'b100, 3'b001};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_count = 0;
    m_wcnt  = 0;
  endtask

  task automatic model_accept(input logic [15:0] x);
    m_was_first = m_first;
    if (m_first) m_mean = x;
    else         m_mean = (m_mean >> 1) + (x >> 1);
    m_first = 1'b0;
    if (m_count < (1 << CW) - 1) m_count++;
    exp_wd = 1'b0;
`ifdef MEAN_CTRL_WINDOW_EN
    m_wcnt++;
    if (m_wcnt == WIN) begin
      exp_wd  = 1'b1;
      m_wcnt  = 0;
      m_first = 1'b1;
    end
`endif
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_reset();
  endtask

  // One full transaction. It checks handshake, per-phase controls, latency, result and the pulse width.
  task automatic send(input logic [15:0] x);
    int n;
    int ph;
    data_in = x;
    bus.sample_valid = 1'b1;
    n = 0;
    while (!bus.sample_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", bus.sample_ready, 1);
    model_accept(x);
    step();
    bus.sample_valid = 1'b0;
    data_in = 16'($urandom);
    n = 1;
    while (!bus.mean_valid && n < 12) begin
      ph = m_was_first ? 3 : n;
      chk("busy_ready", bus.sample_ready, 0);
      if (ph <= 3) begin
        chk("phase_select", bus.select, exp_sel[ph]);
        chk("phase_load", bus.load, exp_ld[ph]);
      end
      step();
      n++;
    end
    chk("latency", n, m_was_first ? 2 : 4);
    chk("reg2", reg2, m_mean);
    chk("count", bus.sample_count, m_count);
    chk("window_done", bus.window_done, exp_wd);
    chk("ready_back", bus.sample_ready, 1);
    chk("idle_select", bus.select, m_first ? 6'b000000 : 6'b000111);
    chk("idle_load", bus.load, 0);
    step();
    chk("mv_pulse", bus.mean_valid, 0);
    chk("wd_pulse", bus.window_done, 0);
  endtask

  initial begin
    logic [15:0] old2;
    int          next_acc;
    int          n;
    logic        took;

    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    reset            = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", bus.sample_ready, 1);
    chk("rst_select", bus.select, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_mv", bus.mean_valid, 0);
    chk("rst_count", bus.sample_count, 0);
    chk("rst_wd", bus.window_done, 0);
    step();
    reset = 1'b0;
    model_reset();
    step();

    // First and second sample.
    send(16'h0010);
    chk("first_reg2", reg2, 16'h0010);
    chk("first_count", bus.sample_count, 1);
    send(16'h0030);
    chk("second_reg2", reg2, 16'h0020);
    chk("second_count", bus.sample_count, 2);

    // Truncation corners.
    do_clear();
    send(16'h0003);
    send(16'h0005);
    chk("trunc_small", reg2, 16'h0003);
    do_clear();
    send(16'hFFFF);
    send(16'hFFFF);
    chk("trunc_max", reg2, 16'hFFFE);

    // Valid held high: an accept happens only when the model says the controller is back in IDLE.
    data_in = 16'h0040;
    bus.sample_valid = 1'b1;
    next_acc = 0;
    for (int i = 0; i < 12; i++) begin
      chk("bp_ready", bus.sample_ready, (i == next_acc) ? 1 : 0);
      took = bus.sample_ready;
      if (took) begin
        model_accept(data_in);
        next_acc = i + (m_was_first ? 2 : 4);
      end
      step();
      if (took) data_in = (data_in == 16'h0040) ? 16'h0080 : 16'h0040;
    end
    bus.sample_valid = 1'b0;
    n = 0;
    while (!bus.mean_valid && n < 10) begin
      step();
      n++;
    end
    chk("bp_mv", bus.mean_valid, 1);
    chk("bp_reg2", reg2, m_mean);
    step();

    // clear during UPDATE abandons the update in flight.
    data_in = 16'h0200;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    step();
    chk("upd_select", bus.select, 6'b001000);
    old2 = reg2;
    do_clear();
    chk("clr_state_ready", bus.sample_ready, 1);
    chk("clr_select", bus.select, 0);
    chk("clr_count", bus.sample_count, 0);
    for (int i = 0; i < 4; i++) begin
      chk("clr_no_mv", bus.mean_valid, 0);
      step();
    end
    chk("clr_reg2_kept", reg2, old2);
    // A handshake in the same cycle as clear is ignored.
    bus.sample_valid = 1'b1;
    data_in = 16'h5555;
    do_clear();
    bus.sample_valid = 1'b0;
    chk("clr_hs_count", bus.sample_count, 0);
    chk("clr_hs_ready", bus.sample_ready, 1);
    step();
    chk("clr_hs_mv", bus.mean_valid, 0);
    send(16'h0100);
    chk("clr_reload", reg2, 16'h0100);

    // Reset during SUM.
    send(16'h0300);
    data_in = 16'h0400;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    chk("sum_load", bus.load, 3'b010);
    reset = 1'b1;
    #1;
    chk("arst_ready", bus.sample_ready, 1);
    chk("arst_select", bus.select, 0);
    chk("arst_load", bus.load, 0);
    chk("arst_mv", bus.mean_valid, 0);
    chk("arst_count", bus.sample_count, 0);
    chk("arst_wd", bus.window_done, 0);
    step();
    reset = 1'b0;
    model_reset();
    step();

    // Random samples and gaps. The run is long enough for sample_count to saturate.
    for (int i = 0; i < 260; i++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) step();
      send(16'($urandom));
    end
    chk("sat_count", bus.sample_count, (1 << CW) - 1);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      send(16'($urandom));
    end

    // Window sequence.
    do_clear();
    send(16'h0008);
    send(16'h0008);
    send(16'h0008);
    send(16'h0008);
    send(16'h0020);
`ifdef MEAN_CTRL_WINDOW_EN
    chk("win_fifth", reg2, 16'h0020);
`else
    chk("win_fifth", reg2, 16'h0014);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
